issue_buffer: RTL and testbench

- Parametrised multi-lane in-order issue buffer between decode and the scoreboard; successor to the single-instruction decode→rename→scoreboard handoff.
- Accepts up to NR_ENQ decoded instructions per cycle and presents up to NR_ISSUE oldest entries per cycle.
- Limits speculation by tracking unresolved control-flow instructions and stalling further control-flow issue at MAX_UNRESOLVED.
- Supports full flush and synchronous clear.

---
 rtl/issue_buffer_pkg.sv | 20 ++
 rtl/cf_credit_counter.sv | 68 ++++++
 rtl/issue_buffer.sv | 135 +++++++++++++
 tb/tb_issue_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_buffer_pkg.sv
// Shared types and helpers for the multi-lane in-order issue buffer.
// scoreboard_entry_t mirrors the decoded-instruction record handed to the scoreboard.
package issue_buffer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
  } scoreboard_entry_t;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/cf_credit_counter.sv
// Tracks issued-but-unresolved control-flow instructions and gates issue lanes
// so that no more than MAX_UNRESOLVED control-flow instructions are in flight.
module cf_credit_counter
  import issue_buffer_pkg::*;
#(
  parameter int NR_ISSUE       = 2,
  parameter int MAX_UNRESOLVED = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  kill_i,
  input  logic [NR_ISSUE-1:0]                   head_present_i,
  input  logic [NR_ISSUE-1:0]                   head_is_cf_i,
  input  logic [NR_ISSUE-1:0]                   issue_ack_i,
  input  logic                                  resolve_i,
  output logic [NR_ISSUE-1:0]                   issue_valid_o,
  output logic [$clog2(MAX_UNRESOLVED+1)-1:0]   cnt_o
);

  localparam int CW = $clog2(MAX_UNRESOLVED + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          open;
  logic          underflow;
  int            cf_below;
  int            inc;
  int            sum;

  // Lane k sees the registered count plus the cf entries in lanes below it.
  always_comb begin
    issue_valid_o = '0;
    cf_below      = 0;
    open          = !kill_i;
    for (int k = 0; k < NR_ISSUE; k++) begin
      if (open && head_present_i[k] &&
          (!head_is_cf_i[k] || (int'(cnt_q) + cf_below < MAX_UNRESOLVED))) begin
        issue_valid_o[k] = 1'b1;
        if (head_is_cf_i[k]) cf_below++;
      end else begin
        open = 1'b0;
      end
    end
  end

  always_comb begin
    inc       = popcount(32'(issue_ack_i & head_is_cf_i));
    sum       = int'(cnt_q) + inc;
    underflow = resolve_i && !kill_i && (sum == 0);
    cnt_d     = cnt_q;
    if (kill_i) begin
      cnt_d = '0;
    end else if (underflow) begin
      cnt_d = '0;
    end else begin
      cnt_d = CW'(sum - int'(resolve_i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !underflow);

endmodule

// File: rtl/issue_buffer.sv
// In-order multi-lane issue buffer between decode and the scoreboard.
// Circular storage of {entry, is_cf}; no enqueue-to-issue bypass.
module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int NR_ENQ         = 2,
  parameter int NR_ISSUE       = 2,
  parameter int MAX_UNRESOLVED = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clr_i,
  input  logic                                flush_i,
  input  scoreboard_entry_t [NR_ENQ-1:0]      enq_instr_i,
  input  logic [NR_ENQ-1:0]                   enq_valid_i,
  input  logic [NR_ENQ-1:0]                   enq_is_cf_i,
  output logic [NR_ENQ-1:0]                   enq_ack_o,
  output scoreboard_entry_t [NR_ISSUE-1:0]    issue_instr_o,
  output logic [NR_ISSUE-1:0]                 issue_valid_o,
  input  logic [NR_ISSUE-1:0]                 issue_ack_i,
  input  logic                                resolve_branch_i,
  output logic [$clog2(MAX_UNRESOLVED+1)-1:0] unresolved_cnt_o,
  output logic                                full_o,
  output logic                                empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  scoreboard_entry_t mem_q [DEPTH];
  scoreboard_entry_t mem_d [DEPTH];
  logic [DEPTH-1:0]  cf_q, cf_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [OW-1:0]     free;
  logic              kill;
  logic              open;
  logic [PW-1:0]     idx;
  logic [NR_ISSUE-1:0] head_present, head_is_cf, ack_eff;
  int                n_enq, n_iss;

  assign kill = flush_i | clr_i;
  assign free = OW'(DEPTH) - occ_q;

  always_comb begin
    enq_ack_o     = '0;
    head_present  = '0;
    head_is_cf    = '0;
    issue_instr_o = '0;
    for (int k = 0; k < NR_ENQ; k++) begin
      enq_ack_o[k] = !kill && enq_valid_i[k] && (k < int'(free));
    end
    for (int k = 0; k < NR_ISSUE; k++) begin
      idx              = rptr_q + PW'(k);
      issue_instr_o[k] = mem_q[idx];
      head_is_cf[k]    = cf_q[idx];
      head_present[k]  = k < int'(occ_q);
    end
  end

  cf_credit_counter #(
    .NR_ISSUE       (NR_ISSUE),
    .MAX_UNRESOLVED (MAX_UNRESOLVED)
  ) i_cf_credit (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .kill_i         (kill),
    .head_present_i (head_present),
    .head_is_cf_i   (head_is_cf),
    .issue_ack_i    (ack_eff),
    .resolve_i      (resolve_branch_i),
    .issue_valid_o  (issue_valid_o),
    .cnt_o          (unresolved_cnt_o)
  );

  // Only a contiguous prefix of valid, acked lanes retires; stray acks are dropped.
  always_comb begin
    ack_eff = '0;
    open    = !kill;
    for (int k = 0; k < NR_ISSUE; k++) begin
      if (open && issue_ack_i[k] && issue_valid_o[k]) ack_eff[k] = 1'b1;
      else                                            open       = 1'b0;
    end
  end

  always_comb begin
    n_enq = popcount(32'(enq_ack_o));
    n_iss = popcount(32'(ack_eff));
    mem_d = mem_q;
    cf_d  = cf_q;
    for (int k = 0; k < NR_ENQ; k++) begin
      if (enq_ack_o[k]) begin
        mem_d[wptr_q + PW'(k)] = enq_instr_i[k];
        cf_d[wptr_q + PW'(k)]  = enq_is_cf_i[k];
      end
    end
    if (kill) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      wptr_d = wptr_q + PW'(n_enq);
      rptr_d = rptr_q + PW'(n_iss);
      occ_d  = occ_q + OW'(n_enq) - OW'(n_iss);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      cf_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      cf_q   <= cf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign full_o  = (occ_q == OW'(DEPTH));
  assign empty_o = (occ_q == '0);

  a_ack_on_valid: assert property (@(posedge clk_i) disable iff (rst_i || kill)
    (issue_ack_i & ~issue_valid_o) == '0);
  a_ack_contig: assert property (@(posedge clk_i) disable iff (rst_i || kill)
    (issue_ack_i & (issue_ack_i + NR_ISSUE'(1))) == '0);

endmodule

// File: tb/tb_issue_buffer.sv
// Scoreboard bench for issue_buffer: a queue-level reference model drives expectations,
// a negedge monitor compares control outputs and pops issued entries in order.
module tb_issue_buffer;
  import issue_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int NE    = 2;
  localparam int NI    = 2;
  localparam int MAXU  = 2;

  logic clk_i = 1'b0;
  logic rst_i, clr_i, flush_i, resolve_branch_i;
  scoreboard_entry_t [NE-1:0] enq_instr_i;
  logic [NE-1:0]              enq_valid_i, enq_is_cf_i, enq_ack_o;
  scoreboard_entry_t [NI-1:0] issue_instr_o;
  logic [NI-1:0]              issue_valid_o, issue_ack_i;
  logic [1:0]                 unresolved_cnt_o;
  logic                       full_o, empty_o;

  issue_buffer #(.DEPTH(DEPTH), .NR_ENQ(NE), .NR_ISSUE(NI), .MAX_UNRESOLVED(MAXU)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .flush_i(flush_i),
    .enq_instr_i(enq_instr_i), .enq_valid_i(enq_valid_i), .enq_is_cf_i(enq_is_cf_i),
    .enq_ack_o(enq_ack_o), .issue_instr_o(issue_instr_o), .issue_valid_o(issue_valid_o),
    .issue_ack_i(issue_ack_i), .resolve_branch_i(resolve_branch_i),
    .unresolved_cnt_o(unresolved_cnt_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    scoreboard_entry_t e;
    logic              cf;
  } item_t;

  item_t             mq[$];
  scoreboard_entry_t sb_q[$];
  int                m_cnt = 0;
  int unsigned       tag = 0;
  logic [NE-1:0]     exp_enq_ack;
  logic [NI-1:0]     exp_valid;
  int                exp_cnt;
  logic              exp_full, exp_empty;
  logic              mon_en = 1'b0;
  int                errors = 0;
  int                checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; the model works on whole entries and plain counts.
  task automatic step(input logic [NE-1:0] ev, input logic [NE-1:0] cfv, input int nack,
                      input logic res, input logic fl, input logic cl);
    int free, n_enq, v, cfs, na, acf;
    logic kill;
    @(posedge clk_i); #1;
    kill = fl | cl;
    for (int k = 0; k < NE; k++) begin
      enq_instr_i[k].pc = tag;
      enq_instr_i[k].op = 8'($urandom);
      enq_instr_i[k].rd = 5'($urandom);
      tag++;
    end
    enq_valid_i      = ev;
    enq_is_cf_i      = cfv;
    flush_i          = fl;
    clr_i            = cl;
    resolve_branch_i = res && (m_cnt > 0);

    exp_cnt   = m_cnt;
    exp_full  = (mq.size() == DEPTH);
    exp_empty = (mq.size() == 0);
    free  = DEPTH - mq.size();
    n_enq = 0;
    for (int k = 0; k < NE; k++) if (!kill && ev[k] && k < free) n_enq++;
    exp_enq_ack = NE'((1 << n_enq) - 1);
    v = 0; cfs = 0;
    if (!kill) begin
      for (int k = 0; k < NI; k++) begin
        if (k >= mq.size()) break;
        if (mq[k].cf && (m_cnt + cfs >= MAXU)) break;
        v++;
        if (mq[k].cf) cfs++;
      end
    end
    exp_valid   = NI'((1 << v) - 1);
    na          = (nack < v) ? nack : v;
    issue_ack_i = kill ? '1 : NI'((1 << na) - 1);

    if (kill) begin
      mq.delete();
      sb_q.delete();
      m_cnt = 0;
    end else begin
      acf = 0;
      for (int i = 0; i < na; i++) begin
        if (mq[0].cf) acf++;
        void'(mq.pop_front());
      end
      for (int k = 0; k < n_enq; k++) begin
        mq.push_back('{e: enq_instr_i[k], cf: cfv[k]});
        sb_q.push_back(enq_instr_i[k]);
      end
      m_cnt = m_cnt + acf - int'(resolve_branch_i);
    end
    mon_en = 1'b1;
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("enq_ack", 64'(enq_ack_o), 64'(exp_enq_ack));
      chk("issue_valid", 64'(issue_valid_o), 64'(exp_valid));
      chk("unresolved_cnt", 64'(unresolved_cnt_o), 64'(exp_cnt));
      chk("full", 64'(full_o), 64'(exp_full));
      chk("empty", 64'(empty_o), 64'(exp_empty));
      for (int k = 0; k < NI; k++) begin
        if (issue_valid_o[k] && issue_ack_i[k]) begin
          if (sb_q.size() == 0) begin
            chk("issue_unexpected", 64'(issue_instr_o[k]), 64'(0));
          end else begin
            chk("issue_entry", 64'(issue_instr_o[k]), 64'(sb_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    enq_valid_i = '0; enq_is_cf_i = '0; enq_instr_i = '0; issue_ack_i = '0;
    flush_i = 1'b0; clr_i = 1'b0; resolve_branch_i = 1'b0;
  endtask

  initial begin
    logic [1:0] ev;
    rst_i = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_full", 64'(full_o), 64'(0));
    chk("rst_valid", 64'(issue_valid_o), 64'(0));
    chk("rst_cnt", 64'(unresolved_cnt_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    // basic enqueue of two non-cf entries, then present and drain
    step(2'b11, 2'b00, 0, 0, 0, 0);
    step(2'b00, 2'b00, 0, 0, 0, 0);
    step(2'b00, 2'b00, 2, 0, 0, 0);
    // fill to 7, then to full, then issue while full
    repeat (3) step(2'b11, 2'b00, 0, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0, 0);
    step(2'b11, 2'b00, 0, 0, 0, 0);
    step(2'b00, 2'b00, 0, 0, 0, 0);
    step(2'b11, 2'b00, 2, 0, 0, 0);
    repeat (4) step(2'b00, 2'b00, 2, 0, 0, 0);
    // three cf entries against a limit of two
    step(2'b11, 2'b11, 2, 0, 0, 0);
    step(2'b01, 2'b01, 2, 0, 0, 0);
    step(2'b00, 2'b00, 2, 0, 0, 0);
    step(2'b00, 2'b00, 2, 0, 0, 0);
    step(2'b00, 2'b00, 2, 1, 0, 0);
    step(2'b00, 2'b00, 2, 0, 0, 0);
    step(2'b00, 2'b00, 0, 1, 0, 0);
    step(2'b00, 2'b00, 0, 1, 0, 0);
    // unresolved 1 with cf,cf at the head; ack plus resolve nets out
    step(2'b01, 2'b01, 0, 0, 0, 0);
    step(2'b11, 2'b11, 1, 0, 0, 0);
    step(2'b00, 2'b00, 1, 1, 0, 0);
    step(2'b00, 2'b00, 0, 0, 0, 0);
    // flush at occupancy 5 with two unresolved
    step(2'b11, 2'b00, 1, 0, 0, 0);
    step(2'b11, 2'b00, 0, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0, 0);
    step(2'b11, 2'b00, 2, 0, 1, 0);
    step(2'b00, 2'b00, 0, 0, 0, 0);
    // clear behaves like flush
    step(2'b11, 2'b01, 0, 0, 0, 0);
    step(2'b11, 2'b00, 1, 0, 0, 1);
    step(2'b00, 2'b00, 0, 0, 0, 0);
    // steady rate-2 stream across pointer wrap, then async reset mid-stream
    repeat (20) step(2'b11, 2'b00, 2, 0, 0, 0);
    @(posedge clk_i);
    mon_en = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_empty", 64'(empty_o), 64'(1));
    chk("async_rst_valid", 64'(issue_valid_o), 64'(0));
    chk("async_rst_cnt", 64'(unresolved_cnt_o), 64'(0));
    mq.delete();
    sb_q.delete();
    m_cnt = 0;
    idle_inputs();
    @(negedge clk_i);
    rst_i = 1'b0;
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ev = 2'(($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 1 : 3));
      step(ev, 2'($urandom), int'($urandom_range(0, 2)), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0));
    end
    @(posedge clk_i);
    mon_en = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
